// File: rtl/mbist_pkg.sv
// Shared types for the MBIST response analyzer: session FSM encoding and
// fail-log depth.
package mbist_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int LOG_DEPTH = 4;

endpackage

// File: rtl/mbist_fail_log.sv
// Small fail-address FIFO with show-ahead read. Only instantiated when
// MBIST_RA_FAILLOG_EN is defined.
module mbist_fail_log
    import mbist_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_i,
    input  logic              push_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic              pop_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic              empty_o
);

    localparam int PTR_W = $clog2(LOG_DEPTH);
    localparam int CNT_W = $clog2(LOG_DEPTH + 1);

    logic [LOG_DEPTH-1:0][ADDR_W-1:0] mem_q;
    logic [PTR_W-1:0]                 wr_q, rd_q;
    logic [CNT_W-1:0]                 cnt_q;
    logic                             push_ok, pop_ok;

    // A push into a full log is dropped, even if a pop frees a slot this cycle.
    assign push_ok = push_i && (cnt_q < CNT_W'(LOG_DEPTH));
    assign pop_ok  = pop_i && (cnt_q != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q <= '0;
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else if (clr_i) begin
            rd_q  <= '0;
            wr_q  <= push_i ? PTR_W'(1) : '0;
            cnt_q <= push_i ? CNT_W'(1) : '0;
            if (push_i) mem_q[0] <= addr_i;
        end else begin
            if (push_ok) begin
                mem_q[wr_q] <= addr_i;
                wr_q        <= wr_q + PTR_W'(1);
            end
            if (pop_ok) rd_q <= rd_q + PTR_W'(1);
            case ({push_ok, pop_ok})
                2'b10:   cnt_q <= cnt_q + CNT_W'(1);
                2'b01:   cnt_q <= cnt_q - CNT_W'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    assign addr_o  = mem_q[rd_q];
    assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/mbist_resp_analyzer.sv
// MBIST response analyzer: per-session masked compare, saturating fail count,
// first-fail capture. Optional fail-address log under MBIST_RA_FAILLOG_EN.
module mbist_resp_analyzer
    import mbist_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              finish,
    input  logic              cmp_valid,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data_t,
    input  logic [DATA_W-1:0] ramout,
    input  logic [DATA_W-1:0] mask,
    output logic              res_valid,
    output logic              gt,
    output logic              eq,
    output logic              lt,
    output logic              fail,
    output logic [CNT_W-1:0]  fail_cnt,
    output logic [ADDR_W-1:0] first_addr,
    output logic [DATA_W-1:0] first_syn,
    output logic              busy,
    output logic              done,
    output logic              pass
`ifdef MBIST_RA_FAILLOG_EN
   ,input  logic              log_rd,
    output logic [ADDR_W-1:0] log_addr,
    output logic              log_empty
`endif
);

    state_e            state_q, state_d;
    logic              res_valid_q, gt_q, eq_q, lt_q, fail_q;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] faddr_q, faddr_d;
    logic [DATA_W-1:0] fsyn_q, fsyn_d;
    logic              fseen_q, fseen_d;

    logic              accept;
    logic [DATA_W-1:0] syn;
    logic              mism;

    // A start in any state opens a session on this edge, so a coincident
    // compare belongs to the new session.
    assign accept = cmp_valid && (start || state_q == ST_RUN);
    assign syn    = (data_t ^ ramout) & ~mask;
    assign mism   = |syn;

    always_comb begin
        state_d = state_q;
        if (start)
            state_d = ST_RUN;
        else if (state_q == ST_RUN && finish)
            state_d = ST_DONE;
    end

    always_comb begin
        cnt_d   = start ? '0 : cnt_q;
        faddr_d = start ? '0 : faddr_q;
        fsyn_d  = start ? '0 : fsyn_q;
        fseen_d = start ? 1'b0 : fseen_q;
        if (accept && mism) begin
            if (cnt_d != '1) cnt_d = cnt_d + CNT_W'(1);
            if (!fseen_d) begin
                fseen_d = 1'b1;
                faddr_d = addr;
                fsyn_d  = syn;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            res_valid_q <= 1'b0;
            gt_q        <= 1'b0;
            eq_q        <= 1'b0;
            lt_q        <= 1'b0;
            fail_q      <= 1'b0;
            cnt_q       <= '0;
            faddr_q     <= '0;
            fsyn_q      <= '0;
            fseen_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            res_valid_q <= accept;
            cnt_q       <= cnt_d;
            faddr_q     <= faddr_d;
            fsyn_q      <= fsyn_d;
            fseen_q     <= fseen_d;
            // Compare flags hold between strobes.
            if (accept) begin
                gt_q   <= (data_t > ramout);
                eq_q   <= (data_t == ramout);
                lt_q   <= (data_t < ramout);
                fail_q <= mism;
            end
        end
    end

    assign res_valid  = res_valid_q;
    assign gt         = gt_q;
    assign eq         = eq_q;
    assign lt         = lt_q;
    assign fail       = fail_q;
    assign fail_cnt   = cnt_q;
    assign first_addr = faddr_q;
    assign first_syn  = fsyn_q;
    assign busy       = (state_q == ST_RUN);
    assign done       = (state_q == ST_DONE);
    assign pass       = done && (cnt_q == '0);

`ifdef MBIST_RA_FAILLOG_EN
    mbist_fail_log #(.ADDR_W(ADDR_W)) u_fail_log (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (start),
        .push_i  (accept && mism),
        .addr_i  (addr),
        .pop_i   (log_rd),
        .addr_o  (log_addr),
        .empty_o (log_empty)
    );
`endif

endmodule

// File: tb/tb_mbist_resp_analyzer.sv
// Directed table-driven bench for mbist_resp_analyzer; a second instance with
// CNT_W=2 covers counter saturation. Log checks run with MBIST_RA_FAILLOG_EN.
module tb_mbist_resp_analyzer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0, finish = 1'b0, cmp_valid = 1'b0;
    logic [7:0] addr = '0, data_t = '0, ramout = '0, mask = '0;

    logic       res_valid, gt, eq, lt, fail, busy, done, pass;
    logic [7:0] fail_cnt, first_addr, first_syn;
    logic       s_res_valid, s_gt, s_eq, s_lt, s_fail, s_busy, s_done, s_pass;
    logic [1:0] s_fail_cnt;
    logic [7:0] s_first_addr, s_first_syn;
`ifdef MBIST_RA_FAILLOG_EN
    logic       log_rd = 1'b0;
    logic [7:0] log_addr, s_log_addr;
    logic       log_empty, s_log_empty;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mbist_resp_analyzer #(.DATA_W(8), .ADDR_W(8), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .finish(finish),
        .cmp_valid(cmp_valid), .addr(addr), .data_t(data_t), .ramout(ramout),
        .mask(mask), .res_valid(res_valid), .gt(gt), .eq(eq), .lt(lt),
        .fail(fail), .fail_cnt(fail_cnt), .first_addr(first_addr),
        .first_syn(first_syn), .busy(busy), .done(done), .pass(pass)
`ifdef MBIST_RA_FAILLOG_EN
       ,.log_rd(log_rd), .log_addr(log_addr), .log_empty(log_empty)
`endif
    );

    mbist_resp_analyzer #(.DATA_W(8), .ADDR_W(8), .CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .start(start), .finish(finish),
        .cmp_valid(cmp_valid), .addr(addr), .data_t(data_t), .ramout(ramout),
        .mask(mask), .res_valid(s_res_valid), .gt(s_gt), .eq(s_eq), .lt(s_lt),
        .fail(s_fail), .fail_cnt(s_fail_cnt), .first_addr(s_first_addr),
        .first_syn(s_first_syn), .busy(s_busy), .done(s_done), .pass(s_pass)
`ifdef MBIST_RA_FAILLOG_EN
       ,.log_rd(1'b0), .log_addr(s_log_addr), .log_empty(s_log_empty)
`endif
    );

    typedef struct {
        logic       st, fin, cv;
        logic [7:0] ad, dt, ro, mk;
        logic       rv, gt, eq, lt, fl, busy, done, pass;
        logic [7:0] cnt, fa, syn;
    } vec_t;

    localparam int NV = 15;
    vec_t vec [NV];

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%0h exp=%0h", n, act, exp);
        end
    endtask

    task automatic drive(input logic st, input logic fin, input logic cv,
                         input logic [7:0] ad, input logic [7:0] dt,
                         input logic [7:0] ro, input logic [7:0] mk);
        start = st; finish = fin; cmp_valid = cv;
        addr = ad; data_t = dt; ramout = ro; mask = mk;
    endtask

    task automatic chk_all_zero(input string n);
        chk({n, ".out"}, {res_valid, gt, eq, lt, fail, busy, done, pass}, 0);
        chk({n, ".cnt"}, {24'd0, fail_cnt}, 0);
        chk({n, ".fa"}, {24'd0, first_addr}, 0);
        chk({n, ".syn"}, {24'd0, first_syn}, 0);
    endtask

    initial begin
        //          st fin cv  addr   dt     ro     mk     rv gt eq lt fl by dn ps cnt    fa     syn
        vec[0]  = '{0, 0, 1, 8'h00, 8'd20, 8'd10, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0, 8'd0, 8'h00, 8'h00};
        vec[1]  = '{1, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0, 0, 1, 0, 0, 8'd0, 8'h00, 8'h00};
        vec[2]  = '{0, 0, 1, 8'h01, 8'd20, 8'd10, 8'h00, 1, 1, 0, 0, 1, 1, 0, 0, 8'd1, 8'h01, 8'h1E};
        vec[3]  = '{0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 1, 0, 0, 1, 1, 0, 0, 8'd1, 8'h01, 8'h1E};
        vec[4]  = '{1, 0, 1, 8'h02, 8'h0F, 8'h0E, 8'h01, 1, 1, 0, 0, 0, 1, 0, 0, 8'd0, 8'h00, 8'h00};
        vec[5]  = '{0, 0, 1, 8'h05, 8'h80, 8'h00, 8'h00, 1, 1, 0, 0, 1, 1, 0, 0, 8'd1, 8'h05, 8'h80};
        vec[6]  = '{0, 0, 1, 8'h09, 8'h01, 8'h03, 8'h00, 1, 0, 0, 1, 1, 1, 0, 0, 8'd2, 8'h05, 8'h80};
        vec[7]  = '{0, 0, 1, 8'h03, 8'h0F, 8'h0E, 8'h01, 1, 1, 0, 0, 0, 1, 0, 0, 8'd2, 8'h05, 8'h80};
        vec[8]  = '{0, 0, 1, 8'h04, 8'h55, 8'h55, 8'h00, 1, 0, 1, 0, 0, 1, 0, 0, 8'd2, 8'h05, 8'h80};
        vec[9]  = '{0, 0, 1, 8'h06, 8'hAA, 8'h55, 8'hFF, 1, 1, 0, 0, 0, 1, 0, 0, 8'd2, 8'h05, 8'h80};
        vec[10] = '{1, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 1, 0, 0, 0, 1, 0, 0, 8'd0, 8'h00, 8'h00};
        vec[11] = '{0, 1, 1, 8'h07, 8'h33, 8'h33, 8'h00, 1, 0, 1, 0, 0, 0, 1, 1, 8'd0, 8'h00, 8'h00};
        vec[12] = '{0, 0, 1, 8'h0B, 8'h01, 8'h02, 8'h00, 0, 0, 1, 0, 0, 0, 1, 1, 8'd0, 8'h00, 8'h00};
        vec[13] = '{1, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 1, 0, 0, 1, 0, 0, 8'd0, 8'h00, 8'h00};
        vec[14] = '{0, 1, 1, 8'h08, 8'h10, 8'h00, 8'h00, 1, 1, 0, 0, 1, 0, 1, 0, 8'd1, 8'h08, 8'h10};

        // Reset state, sampled while reset is held
        @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            drive(vec[i].st, vec[i].fin, vec[i].cv, vec[i].ad, vec[i].dt, vec[i].ro, vec[i].mk);
            @(negedge clk);
            chk($sformatf("v%0d.rv", i), res_valid, vec[i].rv);
            chk($sformatf("v%0d.cmp", i), {gt, eq, lt}, {vec[i].gt, vec[i].eq, vec[i].lt});
            chk($sformatf("v%0d.fail", i), fail, vec[i].fl);
            chk($sformatf("v%0d.st", i), {busy, done, pass}, {vec[i].busy, vec[i].done, vec[i].pass});
            chk($sformatf("v%0d.cnt", i), fail_cnt, vec[i].cnt);
            chk($sformatf("v%0d.fa", i), first_addr, vec[i].fa);
            chk($sformatf("v%0d.syn", i), first_syn, vec[i].syn);
        end

        // Saturation and fail log: six failing compares at addresses 10..15
        drive(1, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("sat.clr", {30'd0, s_fail_cnt}, 0);
        for (int i = 0; i < 6; i++) begin
            drive(0, 0, 1, 8'(10 + i), 8'hFF, 8'h00, 8'h00);
            @(negedge clk);
            chk($sformatf("sat.cnt%0d", i), s_fail_cnt, (i < 3) ? i + 1 : 3);
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("sat.big_cnt", fail_cnt, 6);
        chk("sat.fa", first_addr, 10);
        chk("sat.syn", first_syn, 8'hFF);
`ifdef MBIST_RA_FAILLOG_EN
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("log.empty%0d", i), log_empty, 0);
            chk($sformatf("log.addr%0d", i), log_addr, 10 + i);
            log_rd = 1'b1;
            @(negedge clk);
        end
        log_rd = 1'b0;
        chk("log.drained", log_empty, 1);
        drive(1, 0, 1, 8'h2A, 8'h01, 8'h00, 8'h00);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("log.restart_empty", log_empty, 0);
        chk("log.restart_addr", log_addr, 8'h2A);
`endif

        // Reset mid-RUN
        drive(1, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        drive(0, 0, 1, 8'h33, 8'hF0, 8'h0F, 8'h00);
        @(negedge clk);
        drive(0, 1, 0, 0, 0, 0, 0);
        chk("pre_rst.busy", busy, 1);
        rst_n = 1'b0;
        #1;
        chk_all_zero("midrun_rst");
        chk("midrun_rst.sat", {s_res_valid, s_fail, s_busy, s_done, s_fail_cnt}, 0);
`ifdef MBIST_RA_FAILLOG_EN
        chk("midrun_rst.log", log_empty, 1);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("post_rst%0d", i), {busy, done, pass, res_valid}, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
